// File: rtl/phase_sequencer.sv
// rtl/phase_sequencer.sv - phase/pass sequencer that drives a periodic tick timer
// Steps NPHASE phases of programmable tick length, repeats for a pass count, with hold and abort.
module phase_sequencer #(
   parameter int PW = 2,
   parameter int DW = 8,
   parameter int CW = 8
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      start,
   input  logic                      abort,
   input  logic                      hold,
   input  logic [(2**PW)*DW-1:0]     durations,
   input  logic [CW-1:0]             loops,
   input  logic                      tick,
   output logic                      tmr_enable,
   output logic                      tmr_reset,
   output logic [PW-1:0]             phase,
   output logic                      phase_start,
   output logic                      busy,
   output logic                      done,
   output logic [CW-1:0]             pass_cnt
);

   localparam int NPHASE = 2**PW;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_HOLD} state_t;

   state_t                 state_q, state_d;
   logic [NPHASE*DW-1:0]   dur_q, dur_d;
   logic [CW-1:0]          loops_q, loops_d;
   logic [DW-1:0]          tick_cnt_q, tick_cnt_d;
   logic [CW-1:0]          pass_cnt_q, pass_cnt_d;
   logic [PW-1:0]          phase_q, phase_d;
   logic                   phase_start_q, phase_start_d;
   logic                   busy_q, busy_d;
   logic                   done_q, done_d;
   logic                   tmr_enable_q, tmr_enable_d;
   logic                   tmr_reset_q, tmr_reset_d;

   logic [DW-1:0]          dur_cur;
   logic [DW:0]            d_eff;
   logic [DW:0]            cnt_inc;
   logic [CW-1:0]          pass_inc;
   logic                   phase_end;
   logic                   last_phase;
   logic                   pass_done;

   // A zero-length phase still consumes one tick.
   assign dur_cur    = dur_q[phase_q*DW +: DW];
   assign d_eff      = (dur_cur == '0) ? (DW+1)'(1) : {1'b0, dur_cur};
   assign cnt_inc    = {1'b0, tick_cnt_q} + (DW+1)'(1);
   assign phase_end  = (cnt_inc >= d_eff);
   assign last_phase = (phase_q == PW'(NPHASE-1));
   assign pass_inc   = pass_cnt_q + CW'(1);
   assign pass_done  = (loops_q != '0) && (pass_inc == loops_q);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= S_IDLE;
         dur_q         <= '0;
         loops_q       <= '0;
         tick_cnt_q    <= '0;
         pass_cnt_q    <= '0;
         phase_q       <= '0;
         phase_start_q <= 1'b0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         tmr_enable_q  <= 1'b0;
         tmr_reset_q   <= 1'b1;
      end else begin
         state_q       <= state_d;
         dur_q         <= dur_d;
         loops_q       <= loops_d;
         tick_cnt_q    <= tick_cnt_d;
         pass_cnt_q    <= pass_cnt_d;
         phase_q       <= phase_d;
         phase_start_q <= phase_start_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
         tmr_enable_q  <= tmr_enable_d;
         tmr_reset_q   <= tmr_reset_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      dur_d         = dur_q;
      loops_d       = loops_q;
      tick_cnt_d    = tick_cnt_q;
      pass_cnt_d    = pass_cnt_q;
      phase_d       = phase_q;
      phase_start_d = 1'b0;
      busy_d        = busy_q;
      done_d        = 1'b0;
      tmr_enable_d  = tmr_enable_q;
      tmr_reset_d   = tmr_reset_q;
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               dur_d         = durations;
               loops_d       = loops;
               pass_cnt_d    = '0;
               tick_cnt_d    = '0;
               state_d       = S_RUN;
               busy_d        = 1'b1;
               phase_d       = '0;
               phase_start_d = 1'b1;
               tmr_reset_d   = 1'b0;
               tmr_enable_d  = 1'b1;
            end
         end
         S_RUN: begin
            if (abort) begin
               state_d      = S_IDLE;
               busy_d       = 1'b0;
               tmr_enable_d = 1'b0;
               tmr_reset_d  = 1'b1;
               phase_d      = '0;
            end else begin
               if (tick) begin
                  if (!phase_end) begin
                     tick_cnt_d = cnt_inc[DW-1:0];
                  end else begin
                     tick_cnt_d = '0;
                     if (!last_phase) begin
                        phase_d       = phase_q + PW'(1);
                        phase_start_d = 1'b1;
                     end else begin
                        pass_cnt_d = pass_inc;
                        if (pass_done) begin
                           state_d      = S_IDLE;
                           done_d       = 1'b1;
                           busy_d       = 1'b0;
                           tmr_enable_d = 1'b0;
                           tmr_reset_d  = 1'b1;
                           phase_d      = '0;
                        end else begin
                           phase_d       = '0;
                           phase_start_d = 1'b1;
                        end
                     end
                  end
               end
               // Completion wins over a simultaneous hold request.
               if (hold && (state_d == S_RUN)) begin
                  state_d      = S_HOLD;
                  tmr_enable_d = 1'b0;
               end
            end
         end
         S_HOLD: begin
            if (abort) begin
               state_d      = S_IDLE;
               busy_d       = 1'b0;
               tmr_enable_d = 1'b0;
               tmr_reset_d  = 1'b1;
               phase_d      = '0;
            end else if (!hold) begin
               state_d      = S_RUN;
               tmr_enable_d = 1'b1;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_comb begin
      tmr_enable  = tmr_enable_q;
      tmr_reset   = tmr_reset_q;
      phase       = phase_q;
      phase_start = phase_start_q;
      busy        = busy_q;
      done        = done_q;
      pass_cnt    = pass_cnt_q;
   end

endmodule

// File: tb/tb_phase_sequencer.sv
// tb/tb_phase_sequencer.sv - self-checking bench for phase_sequencer
// Directed scenarios plus random stimulus, compared every cycle against a behavioural model.
module tb_phase_sequencer;

   localparam int PW = 2;
   localparam int DW = 8;
   localparam int CW = 2;
   localparam int NP = 4;

   logic            clk;
   logic            reset;
   logic            start;
   logic            abort;
   logic            hold;
   logic [NP*DW-1:0] durations;
   logic [CW-1:0]   loops;
   logic            tick;
   logic            tmr_enable;
   logic            tmr_reset;
   logic [PW-1:0]   phase;
   logic            phase_start;
   logic            busy;
   logic            done;
   logic [CW-1:0]   pass_cnt;

   phase_sequencer #(.PW(PW), .DW(DW), .CW(CW)) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .abort       (abort),
      .hold        (hold),
      .durations   (durations),
      .loops       (loops),
      .tick        (tick),
      .tmr_enable  (tmr_enable),
      .tmr_reset   (tmr_reset),
      .phase       (phase),
      .phase_start (phase_start),
      .busy        (busy),
      .done        (done),
      .pass_cnt    (pass_cnt)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
   endtask

   // Behavioural model: sequencer mode, current phase, ticks spent in it, passes done.
   localparam int M_IDLE = 0, M_RUN = 1, M_HOLD = 2;
   int m_state = M_IDLE;
   int m_dur[NP];
   int m_loops, m_phase, m_cnt, m_pass;
   bit m_ps, m_done;

   task automatic model_idle();
      m_state = M_IDLE;
      m_phase = 0;
   endtask

   task automatic model_tick();
      int need;
      need = (m_dur[m_phase] == 0) ? 1 : m_dur[m_phase];
      m_cnt++;
      if (m_cnt >= need) begin
         m_cnt = 0;
         if (m_phase < NP-1) begin
            m_phase++;
            m_ps = 1;
         end else begin
            m_pass = (m_pass + 1) % (1 << CW);
            if (m_loops != 0 && m_pass == m_loops) begin
               model_idle();
               m_done = 1;
            end else begin
               m_phase = 0;
               m_ps = 1;
            end
         end
      end
   endtask

   task automatic model_edge();
      m_ps = 0;
      m_done = 0;
      if (reset) begin
         model_idle();
         m_cnt = 0;
         m_pass = 0;
         m_loops = 0;
         for (int i = 0; i < NP; i++) m_dur[i] = 0;
      end else begin
         case (m_state)
            M_IDLE: if (start) begin
               for (int i = 0; i < NP; i++) m_dur[i] = int'(durations[i*DW +: DW]);
               m_loops = int'(loops);
               m_pass = 0;
               m_cnt = 0;
               m_phase = 0;
               m_ps = 1;
               m_state = M_RUN;
            end
            M_RUN: if (abort) model_idle();
               else begin
                  if (tick) model_tick();
                  if (m_state == M_RUN && hold) m_state = M_HOLD;
               end
            default: if (abort) model_idle();
               else if (!hold) m_state = M_RUN;
         endcase
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      check("phase",       int'(phase),       m_phase);
      check("phase_start", int'(phase_start), int'(m_ps));
      check("done",        int'(done),        int'(m_done));
      check("busy",        int'(busy),        int'(m_state != M_IDLE));
      check("tmr_enable",  int'(tmr_enable),  int'(m_state == M_RUN));
      check("tmr_reset",   int'(tmr_reset),   int'(m_state == M_IDLE));
      check("pass_cnt",    int'(pass_cnt),    m_pass);
   endtask

   task automatic start_run(input logic [NP*DW-1:0] d, input logic [CW-1:0] l);
      durations = d;
      loops = l;
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic ticks_until_idle(input int period, input int bound, output int nt);
      int i;
      i = 0;
      nt = 0;
      while (m_state != M_IDLE && i < bound) begin
         tick = ((i % period) == period - 1);
         if (tick) nt++;
         step();
         i++;
      end
      tick = 1'b0;
      if (m_state != M_IDLE) check("run_timeout", 0, 1);
   endtask

   localparam logic [NP*DW-1:0] D3214 = {8'd4, 8'd1, 8'd2, 8'd3};

   int nt;

   initial begin
      reset = 1'b1; start = 1'b0; abort = 1'b0; hold = 1'b0; tick = 1'b0;
      durations = '0; loops = '0;
      step();
      step();
      reset = 1'b0;
      check("rst_phase", int'(phase), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_tmr_reset", int'(tmr_reset), 1);
      check("rst_tmr_enable", int'(tmr_enable), 0);
      step();

      // 1: single pass, 10 ticks
      start_run(D3214, 2'd1);
      check("t1_start_ps", int'(phase_start), 1);
      ticks_until_idle(4, 200, nt);
      check("t1_ticks", nt, 10);
      check("t1_pass", int'(pass_cnt), 1);
      check("t1_busy", int'(busy), 0);
      repeat (3) step();

      // 2: two passes, 20 ticks
      start_run(D3214, 2'd2);
      ticks_until_idle(3, 300, nt);
      check("t2_ticks", nt, 20);
      check("t2_pass", int'(pass_cnt), 2);
      step();

      // 3: zero durations behave as one tick each
      start_run('0, 2'd1);
      ticks_until_idle(2, 100, nt);
      check("t3_ticks", nt, 4);

      // 4: hold mid phase 1, coincident tick counted
      start_run(D3214, 2'd1);
      for (int i = 0; i < 100 && m_phase != 1; i++) begin
         tick = (i % 4 == 3);
         step();
      end
      tick = 1'b1; hold = 1'b1;
      step();
      tick = 1'b0;
      check("t4_hold_en", int'(tmr_enable), 0);
      for (int i = 0; i < 20; i++) begin
         tick = (i % 4 == 1);
         step();
      end
      tick = 1'b0;
      check("t4_frozen_phase", int'(phase), 1);
      hold = 1'b0;
      step();
      check("t4_resume_en", int'(tmr_enable), 1);
      tick = 1'b1;
      step();
      tick = 1'b0;
      check("t4_phase2", int'(phase), 2);
      ticks_until_idle(4, 200, nt);

      // 5a: start while busy does not relatch config
      start_run(D3214, 2'd1);
      durations = '0; loops = 2'd3;
      start = 1'b1; step(); start = 1'b0;
      ticks_until_idle(2, 200, nt);
      check("t5_ticks", nt, 10);
      check("t5_pass", int'(pass_cnt), 1);
      // 5b: abort while holding
      start_run(D3214, 2'd2);
      for (int i = 0; i < 60 && m_pass == 0; i++) begin
         tick = (i % 2 == 1);
         step();
      end
      tick = 1'b0;
      hold = 1'b1; step();
      start = 1'b1; step(); start = 1'b0;
      abort = 1'b1; step(); abort = 1'b0; hold = 1'b0;
      check("t5_abort_busy", int'(busy), 0);
      check("t5_abort_rst", int'(tmr_reset), 1);
      check("t5_abort_pass", int'(pass_cnt), 1);
      for (int i = 0; i < 8; i++) begin
         tick = 1'b1;
         step();
      end
      tick = 1'b0;

      // 6: reset mid-run, then free-running pass counter wraps
      start_run(D3214, 2'd0);
      for (int i = 0; i < 25; i++) begin
         tick = (i % 2 == 0);
         step();
      end
      tick = 1'b0;
      reset = 1'b1; step(); reset = 1'b0;
      check("t6_rst_busy", int'(busy), 0);
      check("t6_rst_pass", int'(pass_cnt), 0);
      check("t6_rst_phase", int'(phase), 0);
      start_run('0, 2'd0);
      for (int i = 0; i < 22; i++) begin
         tick = 1'b1;
         step();
      end
      tick = 1'b0;
      check("t6_wrap_busy", int'(busy), 1);
      check("t6_wrap_pass", int'(pass_cnt), 1);
      abort = 1'b1; step(); abort = 1'b0;

      // random traffic
      for (int r = 0; r < 8; r++) begin
         for (int i = 0; i < 300; i++) begin
            for (int k = 0; k < NP; k++) durations[k*DW +: DW] = DW'($urandom_range(0, 3));
            loops = CW'($urandom_range(0, 3));
            tick  = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 7) == 0) hold = ~hold;
            abort = ($urandom_range(0, 99) == 0);
            start = ($urandom_range(0, 9) == 0);
            reset = ($urandom_range(0, 299) == 0);
            step();
         end
      end
      reset = 1'b0; start = 1'b0; abort = 1'b0; hold = 1'b0; tick = 1'b0;
      step();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/phase_sequencer.md
Name: phase_sequencer

Overview:
Controller that drives the periodic `timer` block. It steps through NPHASE phases, and each phase lasts a programmable number of timer ticks. It owns the timer's enable and reset inputs and consumes its `out` pulse as `tick`. It also repeats the phase sequence a programmable number of passes, and supports hold (pause) and abort.

Parameters:
PW, 2, phase index width; NPHASE = 2**PW
DW, 8, width of each per-phase duration field (ticks)
CW, 8, width of loop count and pass counter

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
start  in  1  start request; sampled only in IDLE
abort  in  1  stop immediately; effective in RUN/HOLD
hold  in  1  level; pause sequencing while high
durations  in  NPHASE*DW  phase i duration at bits [i*DW +: DW]; latched on accepted start
loops  in  CW  passes to run; 0 = run until abort; latched on accepted start
tick  in  1  one-clk pulse from timer out
tmr_enable  out  1  timer enable
tmr_reset  out  1  timer synchronous reset
phase  out  PW  current phase index
phase_start  out  1  one-clk pulse on entry to each phase
busy  out  1  high in RUN/HOLD
done  out  1  one-clk pulse on normal completion
pass_cnt  out  CW  completed passes

Behaviour:
- All outputs are registered.
- Reset values: state=IDLE, tmr_reset=1, tmr_enable=0, phase=0, phase_start=0, busy=0, done=0, pass_cnt=0, internal tick_cnt=0.
- States: IDLE, RUN, HOLD.
- IDLE:
  - tmr_reset=1, tmr_enable=0; tick ignored.
  - start=1 at cycle T: latch durations/loops; clear pass_cnt and tick_cnt.
  - At T+1: state=RUN, busy=1, phase=0, phase_start=1, tmr_reset=0, tmr_enable=1.
- Effective duration: d_eff = durations[phase]. A field value of 0 is treated as 1.
- RUN, on tick:
  - If tick_cnt+1 < d_eff: tick_cnt++.
  - Otherwise: tick_cnt=0.
  - If phase < NPHASE-1: phase++ and phase_start=1 next cycle.
  - If phase = NPHASE-1: pass_cnt++ (wraps modulo 2^CW), then:
    - If loops!=0 and pass_cnt+1==loops: next cycle state=IDLE, done=1, busy=0, tmr_enable=0, tmr_reset=1, phase=0, no phase_start.
    - Else: phase=0, phase_start=1.
- RUN, hold=1: next cycle state=HOLD, tmr_enable=0. A tick in the same cycle is processed first, including any phase advance or completion. Completion takes precedence over HOLD.
- HOLD:
  - tick ignored; tick_cnt, phase and pass_cnt frozen.
  - hold=0: next cycle state=RUN, tmr_enable=1.
  - tmr_reset stays 0 so the timer keeps its partial count.
- abort in RUN or HOLD: next cycle state=IDLE, busy=0, tmr_enable=0, tmr_reset=1, phase=0.
  - No done pulse; pass_cnt retains its value.
  - abort has priority over tick and hold.
- In IDLE, abort has no effect; start with abort in the same cycle is accepted.
- start while busy is ignored, and the latched config is unchanged.
- Latency: one clk from tick to the phase/phase_start/done update. tmr_enable changes one clk after start, hold or abort is sampled.
- reset mid-operation: reset values on the next edge; latched config discarded.

Test Plan:
1. durations phase0..3 = 3,2,1,4; loops=1; tick every 4 clk:
   - phase goes 0→1→2→3 after ticks 3, 5, 6, with phase_start pulse at each entry.
   - done pulses 1 clk after tick 10; pass_cnt=1; busy=0; tmr_reset=1.
2. Same durations, loops=2:
   - 20 ticks to done; phase wraps 3→0 once with phase_start; pass_cnt=2.
3. durations = 0,0,0,0; loops=1:
   - each tick advances phase; done after 4 ticks.
4. hold=1 for 20 clk mid-phase-1 (tick_cnt=1), with ticks continuing:
   - tmr_enable=0 1 clk later; phase and tick_cnt unchanged.
   - After release, phase 1 ends after 1 more tick.
   - tick coincident with hold rising is counted.
5. abort during HOLD:
   - next clk busy=0, tmr_reset=1, phase=0, done never pulses, pass_cnt unchanged.
   - start pulsed while busy has no effect on phase or config.
6. reset asserted mid-RUN with loops=0 (CW=2):
   - all outputs return to reset values next clk.
   - Separate run with loops=0: pass_cnt wraps 3→0 and sequencing continues without done.
